// File: rtl/bcd_leaderboard_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_leaderboard_if
// Description : Game-state, time and scoreboard signals of the BCD leaderboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_leaderboard_if #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 2
);
    logic [1:0]          state;
    logic [4*DIGITS-1:0] time_in;
    logic [IDXW-1:0]     sel;
    logic                clear_scores;
    logic [4*DIGITS-1:0] disp;
    logic                busy;
    logic                rank_valid;
    logic [IDXW-1:0]     rank;
    logic                new_record;
    logic                bcd_err;

    modport master (
        output state, time_in, sel, clear_scores,
        input  disp, busy, rank_valid, rank, new_record, bcd_err
    );

    modport slave (
        input  state, time_in, sel, clear_scores,
        output disp, busy, rank_valid, rank, new_record, bcd_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_leaderboard.sv
`default_nettype none
// ============================================================================
// Module      : bcd_leaderboard
// Description : Sorted best-time board of BCD times with insert-on-compare and
//               7-segment display mux. Optional macro BCD_LEADERBOARD_BCD_CHECK_EN
//               rejects times containing non-BCD nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_leaderboard #(
    parameter int DIGITS = 4,
    parameter int DEPTH  = 4,
    parameter int IDXW   = 2
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    bcd_leaderboard_if.slave  bus
);
    localparam int              c_width = 4 * DIGITS;
    localparam logic [IDXW:0]   c_depth = (IDXW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CMP  = 1'b1
    } fsm_t;

    fsm_t                 r_fsm;
    fsm_t                 w_fsm_next;
    logic [1:0]           r_prev_state;
    logic [c_width-1:0]   r_cap;
    logic                 r_discard;
    logic [c_width-1:0]   r_entry [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [c_width-1:0]   r_disp;
    logic [IDXW-1:0]      r_rank;
    logic                 r_rank_valid;
    logic                 r_new_record;

    logic                 w_trig;
    logic                 w_bad;
    logic                 w_discard;
    logic [IDXW:0]        w_rank;
    logic                 w_insert;
    logic [c_width-1:0]   w_show;

    // Rising edge into compare state only; the clear request wins over a trigger.
    assign w_trig = (bus.state == 2'b11) && (r_prev_state != 2'b11) &&
                    (r_fsm == S_IDLE) && !bus.clear_scores;

`ifdef BCD_LEADERBOARD_BCD_CHECK_EN
    logic r_bcd_err;

    always_comb begin
        w_bad = 1'b0;
        for (int n = 0; n < DIGITS; n++) begin
            if (bus.time_in[4*n +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bcd_err <= 1'b0;
        end else begin
            r_bcd_err <= w_trig && w_bad;
        end
    end

    assign bus.bcd_err = r_bcd_err;
`else
    assign w_bad       = 1'b0;
    assign bus.bcd_err = 1'b0;
`endif

    assign w_discard = (bus.time_in == '0) || w_bad;

    // Valid entries are packed at the front, so the count of entries <= the
    // captured time is the insert position; ties land behind older entries.
    always_comb begin
        w_rank = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_entry[i] <= r_cap)) begin
                w_rank = w_rank + 1'b1;
            end
        end
    end

    assign w_insert = (r_fsm == S_CMP) && !r_discard && (w_rank < c_depth);

    always_comb begin
        w_show = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if ((bus.sel == IDXW'(i)) && r_valid[i]) begin
                w_show = r_entry[i];
            end
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_trig) w_fsm_next = S_CMP;
            S_CMP:   w_fsm_next = S_IDLE;
            default: w_fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fsm        <= S_IDLE;
            r_prev_state <= 2'b00;
        end else begin
            r_fsm        <= w_fsm_next;
            r_prev_state <= bus.state;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_trig) begin
            r_cap     <= bus.time_in;
            r_discard <= w_discard;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid <= '0;
        end else if (w_insert) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if ((IDXW + 1)'(i) > w_rank) begin
                    r_entry[i] <= r_entry[i-1];
                    r_valid[i] <= r_valid[i-1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((IDXW + 1)'(i) == w_rank) begin
                    r_entry[i] <= r_cap;
                    r_valid[i] <= 1'b1;
                end
            end
        end else if (bus.clear_scores && (r_fsm == S_IDLE)) begin
            r_valid <= '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rank       <= '0;
            r_rank_valid <= 1'b0;
            r_new_record <= 1'b0;
            r_disp       <= '0;
        end else begin
            r_rank_valid <= w_insert;
            r_new_record <= w_insert && (w_rank == '0);
            if (w_insert) begin
                r_rank <= w_rank[IDXW-1:0];
            end
            if (bus.state == 2'b00) begin
                r_disp <= w_show;
            end else begin
                r_disp <= bus.time_in;
            end
        end
    end

    assign bus.disp       = r_disp;
    assign bus.busy       = (r_fsm == S_CMP);
    assign bus.rank       = r_rank;
    assign bus.rank_valid = r_rank_valid;
    assign bus.new_record = r_new_record;
endmodule
`default_nettype wire

// File: tb/tb_bcd_leaderboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_leaderboard
// Description : Directed scoreboard bench for bcd_leaderboard (DIGITS=4, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_leaderboard;
    localparam int DIGITS = 4;
    localparam int DEPTH  = 4;
    localparam int IDXW   = 2;

    typedef struct {
        int rank;
        bit nr;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q [$];

    bcd_leaderboard_if #(.DIGITS(DIGITS), .IDXW(IDXW)) bus ();

    bcd_leaderboard #(.DIGITS(DIGITS), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rank pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (bus.new_record) begin
            chk("nr_with_rv", bus.rank_valid, 1);
        end
        if (bus.rank_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rank_valid", q.size(), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_rank", bus.rank, e.rank);
                chk("sb_new_record", bus.new_record, e.nr);
            end
        end
    end

    task automatic trig(input logic [15:0] t, input bit ins, input int rk, input bit bad);
        @(negedge Clk);
        bus.state   = 2'b11;
        bus.time_in = t;
        if (ins) q.push_back('{rk, rk == 0});
        @(negedge Clk);
        chk("busy_t1", bus.busy, 1);
        chk("bcd_err_t1", bus.bcd_err, bad);
        bus.state = 2'b01;
        @(negedge Clk);
        chk("busy_t2", bus.busy, 0);
    endtask

    task automatic check_entry(input int i, input logic [15:0] exp);
        @(negedge Clk);
        bus.state = 2'b00;
        bus.sel   = IDXW'(i);
        @(negedge Clk);
        chk($sformatf("entry%0d", i), bus.disp, exp);
        bus.state = 2'b01;
    endtask

    task automatic pulse_clear();
        @(negedge Clk);
        bus.clear_scores = 1'b1;
        @(negedge Clk);
        bus.clear_scores = 1'b0;
    endtask

    initial begin
        bus.state        = 2'b01;
        bus.time_in      = '0;
        bus.sel          = '0;
        bus.clear_scores = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_disp", bus.disp, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rank_valid", bus.rank_valid, 0);
        chk("rst_rank", bus.rank, 0);
        chk("rst_new_record", bus.new_record, 0);
        chk("rst_bcd_err", bus.bcd_err, 0);
        Reset = 1'b0;

        // First time on an empty board becomes the record.
        trig(16'h0125, 1, 0, 0);
        check_entry(0, 16'h0125);
        check_entry(1, 16'hFFFF);
        pulse_clear();
        check_entry(0, 16'hFFFF);

        // Tie placement behind the older equal entry.
        trig(16'h0200, 1, 0, 0);
        trig(16'h0100, 1, 0, 0);
        trig(16'h0300, 1, 2, 0);
        trig(16'h0200, 1, 2, 0);
        check_entry(1, 16'h0200);
        check_entry(2, 16'h0200);
        check_entry(3, 16'h0300);

        // Full board: worse time rejected, new best drops the tail.
        pulse_clear();
        trig(16'h0100, 1, 0, 0);
        trig(16'h0200, 1, 1, 0);
        trig(16'h0300, 1, 2, 0);
        trig(16'h0400, 1, 3, 0);
        trig(16'h0500, 0, 0, 0);
        check_entry(3, 16'h0400);
        trig(16'h0050, 1, 0, 0);
        check_entry(0, 16'h0050);
        check_entry(3, 16'h0300);

        trig(16'h0000, 0, 0, 0);
        check_entry(0, 16'h0050);

        // Holding compare state must produce exactly one compare.
        @(negedge Clk);
        bus.state   = 2'b11;
        bus.time_in = 16'h0010;
        q.push_back('{0, 1'b1});
        repeat (10) @(negedge Clk);
        bus.state = 2'b01;
        check_entry(0, 16'h0010);
        check_entry(1, 16'h0050);

        @(negedge Clk);
        bus.state   = 2'b10;
        bus.time_in = 16'h4321;
        @(negedge Clk);
        chk("disp_passthrough", bus.disp, 16'h4321);
        bus.state = 2'b01;

        // Clear on the trigger cycle wins.
        @(negedge Clk);
        bus.state        = 2'b11;
        bus.time_in      = 16'h0300;
        bus.clear_scores = 1'b1;
        @(negedge Clk);
        chk("clr_trig_busy", bus.busy, 0);
        bus.clear_scores = 1'b0;
        bus.state        = 2'b01;
        check_entry(0, 16'hFFFF);

        // Reset during the compare cycle aborts the insert.
        trig(16'h0700, 1, 0, 0);
        @(negedge Clk);
        bus.state   = 2'b11;
        bus.time_in = 16'h0600;
        @(negedge Clk);
        chk("abort_busy_t1", bus.busy, 1);
        Reset     = 1'b1;
        bus.state = 2'b01;
        @(negedge Clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_disp", bus.disp, 0);
        chk("abort_rank", bus.rank, 0);
        chk("abort_rank_valid", bus.rank_valid, 0);
        chk("abort_new_record", bus.new_record, 0);
        Reset = 1'b0;
        check_entry(0, 16'hFFFF);

`ifdef BCD_LEADERBOARD_BCD_CHECK_EN
        trig(16'h01A3, 0, 0, 1);
        check_entry(0, 16'hFFFF);
`else
        trig(16'h01A3, 1, 0, 0);
        check_entry(0, 16'h01A3);
`endif

        repeat (3) @(negedge Clk);
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bcd_leaderboard.md
BCD_LEADERBOARD -- requirements
Module: bcd_leaderboard

Interface
REQ-001 The block SHALL expose parameter DIGITS, default 4, number of BCD digits per time value.
REQ-002 The block SHALL expose parameter DEPTH, default 4, number of best-time entries held (DEPTH >= 1).
REQ-003 The block SHALL expose parameter IDXW, default 2, width of entry index and rank signals (2^IDXW >= DEPTH).
REQ-004 Clk  input  1  sole clock; all logic on rising edge.
REQ-005 Reset  input  1  reset, synchronous and active-high.
REQ-006 state  input  2  game state: 00 show board, 01 running, 10 stopped, 11 compare.
REQ-007 time_in  input  4*DIGITS  current time; digit DIGITS-1 in the top nibble, most significant.
REQ-008 sel  input  IDXW  board entry shown while state==00.
REQ-009 clear_scores  input  1  one-cycle request to empty the board.
REQ-010 disp  output  4*DIGITS  registered digits to the 7-segment decoders.
REQ-011 busy  output  1  high while a compare/insert is in flight.
REQ-012 rank_valid  output  1  one-cycle pulse: rank result available.
REQ-013 rank  output  IDXW  0-based board position of the last qualifying time.
REQ-014 new_record  output  1  one-cycle pulse: new time took rank 0.
REQ-015 bcd_err  output  1  one-cycle pulse: rejected non-BCD time (see Configuration).

Function
REQ-016 The board SHALL hold DEPTH entries, each DIGITS BCD digits plus a valid bit, sorted ascending (entry 0 = best/lowest time); empty entries rank below every valid time.
REQ-017 A trigger SHALL be the first cycle with state==11 following a cycle with state!=11; staying in 11 SHALL NOT re-trigger.
REQ-018 On trigger cycle T the block SHALL capture time_in and set busy at T+1.
REQ-019 A captured time of all zeros SHALL be discarded: no insert, no pulses, busy drops at T+2.
REQ-020 At T+1 rank SHALL be computed as the count of valid entries whose time <= captured time (compared MSD first); ties keep the older entry ahead.
REQ-021 If rank < DEPTH, at T+2 entries rank..DEPTH-2 SHALL shift down one place, entry DEPTH-1 is dropped, and the captured time is written valid at rank.
REQ-022 At T+2, rank_valid SHALL pulse with rank only if inserted; new_record SHALL pulse with it if rank==0; busy SHALL clear at T+2.
REQ-023 If rank == DEPTH (board full, time worse than all), no write and no pulses SHALL occur.
REQ-024 A trigger while busy SHALL be ignored.
REQ-025 clear_scores while busy==0 SHALL clear all valid bits next cycle; clear_scores on the trigger cycle SHALL win and drop the trigger; clear_scores while busy SHALL be ignored.
REQ-026 With state==00, disp SHALL register entry[sel] if valid, else 4'hF in every nibble (blank); sel >= DEPTH SHALL also show blank.
REQ-027 With state!=00, disp SHALL register time_in (one-cycle latency).

Reset
REQ-028 Reset SHALL clear all valid bits, disp to 0, busy, rank_valid, rank, new_record, bcd_err to 0, and the previous-state register to 00.
REQ-029 Reset during an insert SHALL abort it with no board write and no pulses.
REQ-030 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-031 With macro BCD_LEADERBOARD_BCD_CHECK_EN defined, a captured time with any nibble > 9 SHALL be discarded as in REQ-019 and bcd_err SHALL pulse at T+1.
REQ-032 Without BCD_LEADERBOARD_BCD_CHECK_EN, nibbles SHALL be compared as plain binary, no check SHALL be made, and bcd_err SHALL be tied to 0.

Verification
REQ-033 Empty board, DIGITS=4/DEPTH=4: trigger with time_in=16'h0125 -> rank_valid, rank=0, new_record at T+2; state 00, sel=0 -> disp=16'h0125.
REQ-034 Board {0100,0200,0300} then trigger 0200 -> rank=2, board {0100,0200,0200,0300}, no new_record.
REQ-035 Full board {0100,0200,0300,0400}, trigger 0500 -> no pulses, board unchanged; trigger 0050 -> rank=0, new_record, 0400 dropped.
REQ-036 Trigger 16'h0000 -> no pulses, board unchanged; state held at 11 for 10 cycles -> exactly one compare.
REQ-037 clear_scores on the trigger cycle -> board empty, no pulses; Reset asserted at T+1 -> no write, all outputs 0.
REQ-038 With BCD_LEADERBOARD_BCD_CHECK_EN, trigger 16'h01A3 -> bcd_err at T+1, board unchanged; without the macro -> inserted, bcd_err stays 0.
